// File: rtl/montar_pin_var.sv
// Variable-length PIN assembler: collects keypad digits (backspace, clear, send) and publishes the PIN.
// Optional inactivity timeout is built only when PIN_TIMEOUT_EN is defined.
module montar_pin_var #(
   parameter int MAX_DIGITS     = 6,
   parameter int MIN_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              key_valid,
   input  logic [3:0]                        key_code,
   output logic [4*MAX_DIGITS-1:0]           pin_digits,
   output logic [$clog2(MAX_DIGITS+1)-1:0]   pin_len,
   output logic                              pin_status,
   output logic                              pin_valid,
   output logic                              pin_err,
   output logic [$clog2(MAX_DIGITS+1)-1:0]   entry_count,
   output logic                              timeout
);

   localparam int DW = 4 * MAX_DIGITS;
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0] MAX_M1_C = CW'(MAX_DIGITS - 1);
   localparam logic [CW-1:0] MIN_C    = CW'(MIN_DIGITS);
   localparam logic [CW-1:0] ONE_C    = CW'(1);
   localparam logic [CW-1:0] ZERO_C   = CW'(0);
   localparam logic [DW-1:0] ALL_F_C  = {DW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            key_d1_q;
   logic            ev_q;
   logic [3:0]      code_q;
   logic [DW-1:0]   buf_q, buf_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   pin_digits_q, pin_digits_d;
   logic [CW-1:0]   pin_len_q, pin_len_d;
   logic            pin_status_q, pin_status_d;
   logic            pin_valid_q, pin_valid_d;
   logic            pin_err_q, pin_err_d;
   logic            timeout_q, timeout_d;

   logic            is_digit_s, is_bksp_s, is_clr_s, is_send_s, key_ev_s, expire_s;

   // The press edge is registered together with its code; decoding acts on the following edge.
   assign is_digit_s = ev_q & (code_q <= 4'd9);
   assign is_bksp_s  = ev_q & (code_q == 4'hB);
   assign is_clr_s   = ev_q & (code_q == 4'hC);
   assign is_send_s  = ev_q & (code_q == 4'hE);
   assign key_ev_s   = is_digit_s | is_bksp_s | is_clr_s | is_send_s;

`ifdef PIN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLAST_C = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TZERO_C = TW'(0);
   localparam logic [TW-1:0] TONE_C  = TW'(1);

   logic [TW-1:0] tmr_q, tmr_d;

   // A real key event at expiry takes precedence and restarts the count.
   assign expire_s = (state_q != S_IDLE) && (tmr_q == TLAST_C) && !key_ev_s;

   // Inactivity counter next value
   always_comb begin
      tmr_d = tmr_q;
      if (key_ev_s || (state_q == S_IDLE) || expire_s) begin
         tmr_d = TZERO_C;
      end else begin
         tmr_d = tmr_q + TONE_C;
      end
   end

   // Inactivity counter register
   always_ff @(posedge clk) begin
      if (!rst) begin
         tmr_q <= TZERO_C;
      end else begin
         tmr_q <= tmr_d;
      end
   end
`else
   logic unused_tmo_s;
   assign unused_tmo_s = (TIMEOUT_CYCLES == 32'sd0);
   assign expire_s     = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         key_d1_q     <= 1'b0;
         ev_q         <= 1'b0;
         code_q       <= 4'h0;
         buf_q        <= ALL_F_C;
         cnt_q        <= ZERO_C;
         pin_digits_q <= ALL_F_C;
         pin_len_q    <= ZERO_C;
         pin_status_q <= 1'b0;
         pin_valid_q  <= 1'b0;
         pin_err_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_d1_q     <= key_valid;
         ev_q         <= key_valid & ~key_d1_q;
         code_q       <= key_code;
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         pin_digits_q <= pin_digits_d;
         pin_len_q    <= pin_len_d;
         pin_status_q <= pin_status_d;
         pin_valid_q  <= pin_valid_d;
         pin_err_q    <= pin_err_d;
         timeout_q    <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (is_digit_s) begin
         if (state_q != S_FULL) begin
            state_d = (cnt_q == MAX_M1_C) ? S_FULL : S_ENTRY;
         end else begin
            state_d = S_FULL;
         end
      end else if (is_bksp_s) begin
         case (state_q)
            S_FULL:  state_d = S_ENTRY;
            S_ENTRY: state_d = (cnt_q == ONE_C) ? S_IDLE : S_ENTRY;
            default: state_d = state_q;
         endcase
      end else if (is_clr_s || is_send_s || expire_s) begin
         state_d = S_IDLE;
      end else begin
         state_d = state_q;
      end
   end

   // Buffer and output next values
   always_comb begin
      buf_d        = buf_q;
      cnt_d        = cnt_q;
      pin_digits_d = pin_digits_q;
      pin_len_d    = pin_len_q;
      pin_status_d = pin_status_q;
      pin_valid_d  = 1'b0;
      pin_err_d    = 1'b0;
      timeout_d    = 1'b0;
      if (is_digit_s) begin
         pin_status_d = 1'b0;
         pin_digits_d = ALL_F_C;
         if (state_q != S_FULL) begin
            buf_d = {buf_q[DW-5:0], code_q};
            cnt_d = cnt_q + ONE_C;
         end else begin
            pin_err_d = 1'b1;
         end
      end else if (is_bksp_s) begin
         if (state_q != S_IDLE) begin
            buf_d = {4'hF, buf_q[DW-1:4]};
            cnt_d = cnt_q - ONE_C;
         end else begin
            buf_d = buf_q;
         end
      end else if (is_clr_s) begin
         buf_d        = ALL_F_C;
         cnt_d        = ZERO_C;
         pin_status_d = 1'b0;
         pin_digits_d = ALL_F_C;
      end else if (is_send_s) begin
         buf_d = ALL_F_C;
         cnt_d = ZERO_C;
         if (cnt_q >= MIN_C) begin
            pin_digits_d = buf_q;
            pin_len_d    = cnt_q;
            pin_status_d = 1'b1;
            pin_valid_d  = 1'b1;
         end else begin
            pin_err_d    = 1'b1;
            pin_status_d = 1'b0;
            pin_digits_d = ALL_F_C;
         end
      end else if (expire_s) begin
         buf_d     = ALL_F_C;
         cnt_d     = ZERO_C;
         timeout_d = 1'b1;
      end else begin
         timeout_d = 1'b0;
      end
   end

   assign pin_digits  = pin_digits_q;
   assign pin_len     = pin_len_q;
   assign pin_status  = pin_status_q;
   assign pin_valid   = pin_valid_q;
   assign pin_err     = pin_err_q;
   assign entry_count = cnt_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_montar_pin_var.sv
// Randomized self-checking bench for montar_pin_var against a digit-queue reference model.
module tb_montar_pin_var;

   localparam int MAXD = 6;
   localparam int MIND = 4;
   localparam int TMO  = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [23:0] pin_digits;
   logic [2:0]  pin_len;
   logic        pin_status;
   logic        pin_valid;
   logic        pin_err;
   logic [2:0]  entry_count;
   logic        timeout;

   int total = 0;
   int bad   = 0;

   logic [3:0]  q[$];
   logic [23:0] m_digits;
   logic [2:0]  m_len;
   logic        m_status;

   montar_pin_var #(.MAX_DIGITS(MAXD), .MIN_DIGITS(MIND), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .pin_digits(pin_digits), .pin_len(pin_len), .pin_status(pin_status),
      .pin_valid(pin_valid), .pin_err(pin_err), .entry_count(entry_count),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] pack_pin();
      logic [23:0] v;
      v = 24'hFFFFFF;
      for (int i = 0; i < q.size(); i++) v[4*i +: 4] = q[q.size()-1-i];
      return v;
   endfunction

   task automatic model_reset();
      q.delete();
      m_digits = 24'hFFFFFF;
      m_len    = 3'd0;
      m_status = 1'b0;
   endtask

   // Reference behaviour of one decoded key; returns the expected pulses.
   task automatic model_key(input logic [3:0] c, output logic ev, output logic ee);
      ev = 1'b0;
      ee = 1'b0;
      if (c <= 4'd9) begin
         m_status = 1'b0;
         m_digits = 24'hFFFFFF;
         if (q.size() == MAXD) ee = 1'b1;
         else q.push_back(c);
      end else if (c == 4'hB) begin
         if (q.size() > 0) void'(q.pop_back());
      end else if (c == 4'hC) begin
         q.delete();
         m_status = 1'b0;
         m_digits = 24'hFFFFFF;
      end else if (c == 4'hE) begin
         if (q.size() >= MIND) begin
            m_digits = pack_pin();
            m_len    = 3'(q.size());
            m_status = 1'b1;
            ev       = 1'b1;
         end else begin
            ee       = 1'b1;
            m_status = 1'b0;
            m_digits = 24'hFFFFFF;
         end
         q.delete();
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic ee);
      check_val({tag, ".valid"},  32'(pin_valid),   32'(ev));
      check_val({tag, ".err"},    32'(pin_err),     32'(ee));
      check_val({tag, ".digits"}, 32'(pin_digits),  32'(m_digits));
      check_val({tag, ".len"},    32'(pin_len),     32'(m_len));
      check_val({tag, ".status"}, 32'(pin_status),  32'(m_status));
      check_val({tag, ".count"},  32'(entry_count), 32'(q.size()));
      check_val({tag, ".tmo"},    32'(timeout),     32'd0);
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, ".digits"}, 32'(pin_digits),  32'h00FFFFFF);
      check_val({tag, ".len"},    32'(pin_len),     32'd0);
      check_val({tag, ".status"}, 32'(pin_status),  32'd0);
      check_val({tag, ".valid"},  32'(pin_valid),   32'd0);
      check_val({tag, ".err"},    32'(pin_err),     32'd0);
      check_val({tag, ".count"},  32'(entry_count), 32'd0);
      check_val({tag, ".tmo"},    32'(timeout),     32'd0);
   endtask

   // Press a key, check the result two edges after the rise, then hold it for 'hold' cycles.
   task automatic press(input logic [3:0] c, input int hold);
      logic ev, ee;
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_code  = 4'($urandom);
      @(negedge clk);
      model_key(c, ev, ee);
      check_all("key", ev, ee);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val("hold.valid", 32'(pin_valid),   32'd0);
         check_val("hold.err",   32'(pin_err),     32'd0);
         check_val("hold.count", 32'(entry_count), 32'(q.size()));
      end
      key_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] seq[];
      int n;
      int hits;
      logic seen;

      rst = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'h0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst = 1'b1;

      seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hE};
      foreach (seq[i]) press(seq[i], 0);
      check_val("tp1.digits", 32'(pin_digits), 32'h00FF1234);
      check_val("tp1.len",    32'(pin_len),    32'd4);
      check_val("tp1.status", 32'(pin_status), 32'd1);

      seq = '{4'h1, 4'h2, 4'h3, 4'hE};
      foreach (seq[i]) press(seq[i], 0);
      check_val("tp2.status", 32'(pin_status), 32'd0);
      check_val("tp2.digits", 32'(pin_digits), 32'h00FFFFFF);

      seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
      foreach (seq[i]) press(seq[i], 1);
      check_val("tp3.digits", 32'(pin_digits), 32'h00123456);
      check_val("tp3.len",    32'(pin_len),    32'd6);

      seq = '{4'h5, 4'h6, 4'hB, 4'h7, 4'h8, 4'h9, 4'hE};
      foreach (seq[i]) press(seq[i], 0);
      check_val("tp4.digits", 32'(pin_digits), 32'h00FF5789);
      check_val("tp4.len",    32'(pin_len),    32'd4);
      press(4'h3, 0);
      check_val("tp4b.status", 32'(pin_status), 32'd0);
      check_val("tp4b.digits", 32'(pin_digits), 32'h00FFFFFF);

      press(4'hC, 0);
      press(4'h1, 20);
      check_val("tp5.count", 32'(entry_count), 32'd1);
      press(4'hE, 0);
      check_val("tp5.status", 32'(pin_status), 32'd0);

      seq = '{4'h4, 4'hA, 4'hD, 4'hF, 4'hB, 4'hB, 4'hB};
      foreach (seq[i]) press(seq[i], 0);

      for (int k = 0; k < 300; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) press(4'($urandom_range(10, 15)), $urandom_range(0, 3));
         else press(4'($urandom_range(0, 9)), $urandom_range(0, 3));
      end

      press(4'h1, 0);
      press(4'h2, 0);
      rst = 1'b0;
      @(negedge clk);
      model_reset();
      check_reset("midrst");
      rst = 1'b1;
      hits = 0;
      repeat (5) begin
         @(negedge clk);
         if (pin_valid || pin_err || timeout) hits++;
      end
      check_val("midrst.pulses", 32'(hits), 32'd0);

`ifdef PIN_TIMEOUT_EN
      press(4'h9, 0);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 300) begin
         @(negedge clk);
         n++;
         if (timeout) seen = 1'b1;
      end
      q.delete();
      check_val("tmo.seen",   32'(seen),        32'd1);
      check_val("tmo.window", 32'(n >= 95 && n <= 100), 32'd1);
      check_val("tmo.count",  32'(entry_count), 32'd0);
      check_val("tmo.status", 32'(pin_status),  32'(m_status));
      @(negedge clk);
      check_val("tmo.pulse1", 32'(timeout), 32'd0);
`else
      press(4'h9, 0);
      hits = 0;
      repeat (150) begin
         @(negedge clk);
         if (timeout) hits++;
      end
      check_val("notmo.hits",  32'(hits),        32'd0);
      check_val("notmo.count", 32'(entry_count), 32'd1);
      press(4'hC, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
